// File: rtl/stim_pkg.sv
// Shared types for the stimulus-vector sequencer: FSM states, widths and the
// table entry layout {stim[5:0], exp}.
package stim_pkg;

  localparam int STIM_W = 6;
  localparam int ERR_W  = 8;
  localparam int VEC_W  = STIM_W + 1;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    APPLY  = 2'd1,
    SAMPLE = 2'd2,
    DONE   = 2'd3
  } state_t;

  typedef struct packed {
    logic [STIM_W-1:0] stim;
    logic              exp;
  } vec_entry_t;

endpackage

// File: rtl/stim_hold_timer.sv
// Loadable down-counter with a zero flag; times how long each vector is held.
module stim_hold_timer #(
  parameter int CW = 3
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          load_i,
  input  logic [CW-1:0] load_val_i,
  input  logic          en_i,
  output logic [CW-1:0] cnt_o,
  output logic          zero_o
);

  logic [CW-1:0] cnt_q, cnt_d;

  always_comb begin
    cnt_d = cnt_q;
    if (load_i)
      cnt_d = load_val_i;
    else if (en_i && (cnt_q != '0))
      cnt_d = cnt_q - 1'b1;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) cnt_q <= '0;
    else        cnt_q <= cnt_d;
  end

  assign cnt_o  = cnt_q;
  assign zero_o = (cnt_q == '0);

endmodule

// File: rtl/stim_vector_sequencer.sv
// Applies a loadable table of 6-bit vectors to a DUT, samples Y after a hold
// interval and counts mismatches. Optional STIM_FIRST_FAIL_EN adds first-fail capture.
module stim_vector_sequencer
  import stim_pkg::*;
#(
  parameter int NUM_VEC     = 4,
  parameter int HOLD_CYCLES = 5,
  parameter int AW          = 4
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              start,
  input  logic              wr_en,
  input  logic [AW-1:0]     wr_addr,
  input  logic [VEC_W-1:0]  wr_data,
  input  logic              y_in,
  output logic [STIM_W-1:0] stim_out,
  output logic              busy,
  output logic              done,
  output logic              pass,
  output logic [ERR_W-1:0]  err_count,
  output logic [AW-1:0]     vec_idx,
`ifdef STIM_FIRST_FAIL_EN
  output logic              first_fail_vld,
  output logic [AW-1:0]     first_fail_idx,
`endif
  output logic [1:0]        dbg_state
);

  localparam int            CW         = $clog2(HOLD_CYCLES + 1);
  localparam logic [CW-1:0] HOLD_LOAD  = CW'(HOLD_CYCLES - 1);
  localparam logic [AW:0]   NUM_VEC_W  = (AW+1)'(NUM_VEC);
  localparam logic [AW-1:0] LAST_IDX   = AW'(NUM_VEC - 1);

  state_t            state_q;
  vec_entry_t        tbl_q [2**AW];
  logic [STIM_W-1:0] stim_q;
  logic              busy_q, done_q, pass_q;
  logic [ERR_W-1:0]  err_q, err_upd;
  logic [AW-1:0]     vec_idx_q;
`ifdef STIM_FIRST_FAIL_EN
  logic              ff_vld_q;
  logic [AW-1:0]     ff_idx_q;
`endif

  logic       wr_ok, mismatch, err_inc, last_vec;
  logic       timer_load, timer_en, timer_zero;
  logic [CW-1:0] timer_cnt;
  vec_entry_t wr_ent, first_ent, next_ent;

  // Writes are only accepted while idle, so the table is frozen during a run.
  assign wr_ok     = wr_en && (state_q == IDLE) && ({1'b0, wr_addr} < NUM_VEC_W);
  assign wr_ent    = vec_entry_t'(wr_data);
  // A same-cycle write to entry 0 is forwarded so the run starts on the new data.
  assign first_ent = (wr_ok && (wr_addr == '0)) ? wr_ent : tbl_q[0];
  assign next_ent  = tbl_q[vec_idx_q + 1'b1];
  assign last_vec  = (vec_idx_q == LAST_IDX);
  assign mismatch  = (y_in != tbl_q[vec_idx_q].exp);
  assign err_inc   = (state_q == SAMPLE) && mismatch && (err_q != '1);
  assign err_upd   = err_inc ? err_q + 1'b1 : err_q;

  assign timer_load = ((state_q == IDLE) && start) || ((state_q == SAMPLE) && !last_vec);
  assign timer_en   = (state_q == APPLY);

  stim_hold_timer #(.CW(CW)) u_hold_timer (
    .clk        (clk),
    .rst_n      (rst_n),
    .load_i     (timer_load),
    .load_val_i (HOLD_LOAD),
    .en_i       (timer_en),
    .cnt_o      (timer_cnt),
    .zero_o     (timer_zero)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < 2**AW; i++) tbl_q[i] <= '0;
    end else if (wr_ok) begin
      tbl_q[wr_addr] <= wr_ent;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= IDLE;
      stim_q    <= '0;
      busy_q    <= 1'b0;
      done_q    <= 1'b0;
      pass_q    <= 1'b0;
      err_q     <= '0;
      vec_idx_q <= '0;
`ifdef STIM_FIRST_FAIL_EN
      ff_vld_q  <= 1'b0;
      ff_idx_q  <= '0;
`endif
    end else begin
      done_q <= 1'b0;
      err_q  <= err_upd;
      case (state_q)
        IDLE: begin
          if (start) begin
            err_q     <= '0;
            pass_q    <= 1'b0;
            vec_idx_q <= '0;
            stim_q    <= first_ent.stim;
            busy_q    <= 1'b1;
            state_q   <= APPLY;
`ifdef STIM_FIRST_FAIL_EN
            ff_vld_q  <= 1'b0;
            ff_idx_q  <= '0;
`endif
          end
        end
        APPLY: begin
          if (timer_zero) state_q <= SAMPLE;
        end
        SAMPLE: begin
`ifdef STIM_FIRST_FAIL_EN
          if (mismatch && !ff_vld_q) begin
            ff_vld_q <= 1'b1;
            ff_idx_q <= vec_idx_q;
          end
`endif
          if (last_vec) begin
            done_q  <= 1'b1;
            pass_q  <= (err_upd == '0);
            state_q <= DONE;
          end else begin
            vec_idx_q <= vec_idx_q + 1'b1;
            stim_q    <= next_ent.stim;
            state_q   <= APPLY;
          end
        end
        DONE: begin
          busy_q  <= 1'b0;
          state_q <= IDLE;
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  assign stim_out  = stim_q;
  assign busy      = busy_q;
  assign done      = done_q;
  assign pass      = pass_q;
  assign err_count = err_q;
  assign vec_idx   = vec_idx_q;
  assign dbg_state = state_q;
`ifdef STIM_FIRST_FAIL_EN
  assign first_fail_vld = ff_vld_q;
  assign first_fail_idx = ff_idx_q;
`endif

  logic unused_ok;
  assign unused_ok = ^timer_cnt;

endmodule

// File: tb/tb_stim_vector_sequencer.sv
// Directed bench for stim_vector_sequencer with a Y=A&C DUT model and
// hand-computed expected results per run.
module tb_stim_vector_sequencer;

  localparam int NUM_VEC = 4;
  localparam int AW      = 4;

  logic          clk = 1'b0;
  logic          rst_n;
  logic          start, wr_en, y_in;
  logic [AW-1:0] wr_addr;
  logic [6:0]    wr_data;
  logic [5:0]    stim_out;
  logic          busy, done, pass;
  logic [7:0]    err_count;
  logic [AW-1:0] vec_idx;
  logic [1:0]    dbg_state;
`ifdef STIM_FIRST_FAIL_EN
  logic          first_fail_vld;
  logic [AW-1:0] first_fail_idx;
`endif

  int n_checks = 0;
  int n_fail   = 0;

  logic [6:0] model_tbl [NUM_VEC];
  logic [5:0] exp_q [$];

  stim_vector_sequencer #(.NUM_VEC(NUM_VEC), .HOLD_CYCLES(5), .AW(AW)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .start     (start),
    .wr_en     (wr_en),
    .wr_addr   (wr_addr),
    .wr_data   (wr_data),
    .y_in      (y_in),
    .stim_out  (stim_out),
    .busy      (busy),
    .done      (done),
    .pass      (pass),
    .err_count (err_count),
    .vec_idx   (vec_idx),
`ifdef STIM_FIRST_FAIL_EN
    .first_fail_vld (first_fail_vld),
    .first_fail_idx (first_fail_idx),
`endif
    .dbg_state (dbg_state)
  );

  // Clock and DUT model: Y = A & C (A = bit5, C = bit3)
  always #5 clk = ~clk;
  assign y_in = stim_out[5] & stim_out[3];

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic set_tbl(input logic [6:0] e0, input logic [6:0] e1,
                         input logic [6:0] e2, input logic [6:0] e3);
    model_tbl[0] = e0; model_tbl[1] = e1; model_tbl[2] = e2; model_tbl[3] = e3;
  endtask

  task automatic load_table();
    for (int i = 0; i < NUM_VEC; i++) begin
      @(negedge clk);
      wr_en = 1'b1; wr_addr = AW'(i); wr_data = model_tbl[i];
    end
    @(negedge clk);
    wr_en = 1'b0;
  endtask

  // One full run; cycle k is the period after the k-th edge following start.
  task automatic run_seq(input string tag, input bit disturb, input bit sat, input bit wr0,
                         input logic [6:0] wr0_data, input int exp_err, input bit exp_pass,
                         input int exp_ff);
    logic [5:0] cur;
    int         done_n;
    cur = '0;
    done_n = 0;
    if (wr0) model_tbl[0] = wr0_data;
    for (int i = 0; i < NUM_VEC; i++) exp_q.push_back(model_tbl[i][6:1]);
    @(negedge clk);
    start = 1'b1;
    if (wr0) begin
      wr_en = 1'b1; wr_addr = '0; wr_data = wr0_data;
    end
    @(negedge clk);
    start = 1'b0; wr_en = 1'b0;
    for (int k = 1; k <= 26; k++) begin
      if (k > 1) @(negedge clk);
      if (done) done_n++;
      if (k <= 24 && (k % 6) == 1) begin
        cur = (exp_q.size() > 0) ? exp_q.pop_front() : 6'h3f;
        check_eq({tag, " stim_first"}, 32'(stim_out), 32'(cur));
        check_eq({tag, " vec_idx"}, 32'(vec_idx), 32'((k - 1) / 6));
      end
      if (k <= 24 && (k % 6) == 0)
        check_eq({tag, " stim_last"}, 32'(stim_out), 32'(cur));
      if (k == 1)  check_eq({tag, " busy_on"}, 32'(busy), 32'd1);
      if (k == 24) check_eq({tag, " done_early"}, 32'(done), 32'd0);
      if (k == 25) begin
        check_eq({tag, " done"}, 32'(done), 32'd1);
        check_eq({tag, " busy_done"}, 32'(busy), 32'd1);
        check_eq({tag, " err_count"}, 32'(err_count), 32'(exp_err));
        check_eq({tag, " pass"}, 32'(pass), 32'(exp_pass));
`ifdef STIM_FIRST_FAIL_EN
        check_eq({tag, " ff_vld"}, 32'(first_fail_vld), 32'(exp_ff >= 0));
        if (exp_ff >= 0) check_eq({tag, " ff_idx"}, 32'(first_fail_idx), 32'(exp_ff));
`endif
      end
      if (k == 26) begin
        check_eq({tag, " busy_off"}, 32'(busy), 32'd0);
        check_eq({tag, " stim_hold"}, 32'(stim_out), 32'(cur));
        check_eq({tag, " pass_hold"}, 32'(pass), 32'(exp_pass));
      end
      if (sat && k == 2) force dut.err_q = 8'd254;
      if (sat && k == 3) release dut.err_q;
      start = disturb && (k == 3 || k == 10);
      wr_en = disturb && (k == 10);
      wr_addr = 4'd2;
      wr_data = 7'h7f;
    end
    start = 1'b0; wr_en = 1'b0;
    check_eq({tag, " done_pulses"}, 32'(done_n), 32'd1);
  endtask

  initial begin
    rst_n = 1'b0; start = 1'b0; wr_en = 1'b0; wr_addr = '0; wr_data = '0;
    repeat (3) @(negedge clk);
    check_eq("rst stim_out", 32'(stim_out), 32'd0);
    check_eq("rst busy", 32'(busy), 32'd0);
    check_eq("rst done", 32'(done), 32'd0);
    check_eq("rst pass", 32'(pass), 32'd0);
    check_eq("rst err", 32'(err_count), 32'd0);
    check_eq("rst vec_idx", 32'(vec_idx), 32'd0);
    check_eq("rst state", 32'(dbg_state), 32'd0);
    rst_n = 1'b1;

    // Matching table: all pass.
    set_tbl({6'b100100, 1'b0}, {6'b001100, 1'b0}, {6'b101100, 1'b1}, {6'b101101, 1'b1});
    load_table();
    run_seq("nominal", 1'b0, 1'b0, 1'b0, '0, 0, 1'b1, -1);

    // Entry 1 expects 1 but Y=0 there.
    model_tbl[1] = {6'b001100, 1'b1};
    load_table();
    run_seq("one_err", 1'b0, 1'b0, 1'b0, '0, 1, 1'b0, 1);

    // Every expected bit inverted; repeated runs must not accumulate.
    set_tbl({6'b100100, 1'b1}, {6'b001100, 1'b1}, {6'b101100, 1'b0}, {6'b101101, 1'b0});
    load_table();
    for (int r = 0; r < 70; r++) begin
      for (int i = 0; i < NUM_VEC; i++) exp_q.push_back(model_tbl[i][6:1]);
      @(negedge clk); start = 1'b1;
      @(negedge clk); start = 1'b0;
      for (int w = 0; w < 40 && !done; w++) @(negedge clk);
      check_eq("rerun done", 32'(done), 32'd1);
      check_eq("rerun err", 32'(err_count), 32'd4);
      check_eq("rerun pass", 32'(pass), 32'd0);
      exp_q.delete();
    end

    run_seq("saturate", 1'b0, 1'b1, 1'b0, '0, 255, 1'b0, 0);

    // Start/write while busy are ignored; a clean rerun proves entry 2 survived.
    set_tbl({6'b100100, 1'b0}, {6'b001100, 1'b0}, {6'b101100, 1'b1}, {6'b101101, 1'b1});
    load_table();
    run_seq("busy_ign", 1'b1, 1'b0, 1'b0, '0, 0, 1'b1, -1);
    run_seq("tbl_frozen", 1'b0, 1'b0, 1'b0, '0, 0, 1'b1, -1);

    // Reset mid-run at cycle 12.
    @(negedge clk); start = 1'b1;
    @(negedge clk); start = 1'b0;
    repeat (11) @(negedge clk);
    rst_n = 1'b0;
    #1;
    check_eq("midrst stim", 32'(stim_out), 32'd0);
    check_eq("midrst busy", 32'(busy), 32'd0);
    check_eq("midrst err", 32'(err_count), 32'd0);
    check_eq("midrst vec_idx", 32'(vec_idx), 32'd0);
    check_eq("midrst state", 32'(dbg_state), 32'd0);
    @(negedge clk); rst_n = 1'b1;
    set_tbl('0, '0, '0, '0);
    run_seq("cleared_tbl", 1'b0, 1'b0, 1'b0, '0, 0, 1'b1, -1);

    set_tbl({6'b100100, 1'b0}, {6'b001100, 1'b0}, {6'b101100, 1'b1}, {6'b101101, 1'b1});
    load_table();
    run_seq("reload", 1'b0, 1'b0, 1'b0, '0, 0, 1'b1, -1);

    // Out-of-range write then same-cycle start+write to entry 0.
    @(negedge clk); wr_en = 1'b1; wr_addr = 4'd5; wr_data = 7'h7f;
    @(negedge clk); wr_en = 1'b0;
    run_seq("start_wr0", 1'b0, 1'b0, 1'b1, {6'b101000, 1'b1}, 0, 1'b1, -1);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
